// File: rtl/tlul_host_mux_adapter.sv
// TL-UL types plus an N-channel core-to-TL-UL host adapter: round-robin
// arbitration of req/gnt ports onto one A channel (channel index in a_source),
// per-channel outstanding limit, and D-beat routing back by d_source.
package tlul_pkg;
    localparam logic [2:0]  PUT_FULL_DATA    = 3'h0;
    localparam logic [2:0]  PUT_PARTIAL_DATA = 3'h1;
    localparam logic [2:0]  GET              = 3'h4;
    localparam logic [15:0] A_USER_DEFAULT   = 16'h0000;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic [15:0] a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [15:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

// Per-channel slice: outstanding counter, eligibility, response capture.
module tlul_host_mux_ch #(
    parameter int MaxReqs = 2,
    parameter int CntW    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        gnt,
    input  logic        d_hit,
    input  logic [31:0] d_data,
    input  logic        d_error,
    output logic        elig,
    output logic        valid,
    output logic [31:0] rdata,
    output logic        err
);
    logic [CntW-1:0] cnt;
    logic [31:0]     rdata_q;
    logic            err_q;

    // Eligibility looks only at the registered count, so a response frees a slot next cycle.
    assign elig  = req && (cnt < CntW'(MaxReqs));
    // A beat for a channel with nothing outstanding is not a response.
    assign valid = d_hit && (cnt != '0);
    assign rdata = valid ? d_data : rdata_q;
    assign err   = valid ? d_error : err_q;

    // Outstanding count: grant and response in the same cycle cancel out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (gnt && !valid) begin
            cnt <= cnt + 1'b1;
        end else if (!gnt && valid) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Hold the last response so rdata/err stay stable between beats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (valid) begin
            rdata_q <= d_data;
            err_q   <= d_error;
        end
    end
endmodule

module tlul_host_mux_adapter
    import tlul_pkg::*;
#(
    parameter int NumCh   = 2,
    parameter int MaxReqs = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NumCh-1:0]      req_i,
    output logic [NumCh-1:0]      gnt_o,
    input  logic [NumCh*32-1:0]   addr_i,
    input  logic [NumCh-1:0]      we_i,
    input  logic [NumCh*32-1:0]   wdata_i,
    input  logic [NumCh*4-1:0]    be_i,
    output logic [NumCh-1:0]      valid_o,
    output logic [NumCh*32-1:0]   rdata_o,
    output logic [NumCh-1:0]      err_o,
    output logic                  unexp_o,
    output tl_h2d_t               tl_h_c_a,
    input  tl_d2h_t               tl_h_c_d
);
    localparam int ChW  = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int CntW = $clog2(MaxReqs + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state;
    logic [ChW-1:0]   ptr, lock_idx, win, sel, ptr_next;
    logic [ChW:0]     idx;
    logic [NumCh-1:0] elig, d_match;
    logic             any_elig, a_valid, a_fire, src_ok, unexp_q;
    logic [31:0]      sel_addr, sel_wdata;
    logic [3:0]       sel_be;
    logic             sel_we;
    logic             unused_d;

    // Round-robin: lowest offset from ptr among eligible channels wins.
    always_comb begin
        win      = '0;
        any_elig = 1'b0;
        idx      = '0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (ChW+1)'(i);
            if (idx >= (ChW+1)'(NumCh)) idx = idx - (ChW+1)'(NumCh);
            if (elig[idx[ChW-1:0]]) begin
                win      = idx[ChW-1:0];
                any_elig = 1'b1;
            end
        end
    end

    // While LOCKED the stalled beat keeps its channel so A fields stay stable.
    assign sel      = (state == LOCKED) ? lock_idx : win;
    assign a_valid  = reset && ((state == LOCKED) || any_elig);
    assign a_fire   = a_valid && tl_h_c_d.a_ready;
    assign gnt_o    = a_fire ? (NumCh'(1) << sel) : '0;
    assign ptr_next = (int'(sel) == NumCh - 1) ? '0 : sel + 1'b1;

    // Arbitration state: lock on a stalled beat, advance pointer on acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lock_idx <= '0;
            ptr      <= '0;
        end else if (a_fire) begin
            state <= IDLE;
            ptr   <= ptr_next;
        end else if (a_valid) begin
            state    <= LOCKED;
            lock_idx <= sel;
        end
    end

    assign sel_we    = we_i[sel];
    assign sel_be    = be_i[4*int'(sel) +: 4];
    assign sel_addr  = addr_i[32*int'(sel) +: 32];
    assign sel_wdata = wdata_i[32*int'(sel) +: 32];

    // Build the A beat from the selected channel.
    always_comb begin
        tl_h_c_a           = '0;
        tl_h_c_a.a_valid   = a_valid;
        tl_h_c_a.a_opcode  = sel_we ? ((sel_be == 4'hF) ? PUT_FULL_DATA : PUT_PARTIAL_DATA) : GET;
        tl_h_c_a.a_param   = 3'h0;
        tl_h_c_a.a_size    = 2'd2;
        tl_h_c_a.a_source  = 8'(sel);
        tl_h_c_a.a_address = {sel_addr[31:2], 2'b00};
        tl_h_c_a.a_mask    = sel_we ? sel_be : 4'hF;
        tl_h_c_a.a_data    = sel_we ? sel_wdata : 32'h0;
        tl_h_c_a.a_user    = A_USER_DEFAULT;
        tl_h_c_a.d_ready   = 1'b1;
    end

    // Full 8-bit compare rejects both out-of-range and nonzero upper source bits.
    assign src_ok = tl_h_c_d.d_valid && (tl_h_c_d.d_source < 8'(NumCh));

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        assign d_match[c] = src_ok && (tl_h_c_d.d_source[ChW-1:0] == ChW'(c));
        tlul_host_mux_ch #(.MaxReqs(MaxReqs), .CntW(CntW)) u_ch (
            .clock   (clock),
            .reset   (reset),
            .req     (req_i[c]),
            .gnt     (gnt_o[c]),
            .d_hit   (d_match[c]),
            .d_data  (tl_h_c_d.d_data),
            .d_error (tl_h_c_d.d_error),
            .elig    (elig[c]),
            .valid   (valid_o[c]),
            .rdata   (rdata_o[32*c +: 32]),
            .err     (err_o[c])
        );
    end

    // Sticky flag for any D beat that no channel accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            unexp_q <= 1'b0;
        end else if (tl_h_c_d.d_valid && !(|valid_o)) begin
            unexp_q <= 1'b1;
        end
    end

    assign unexp_o  = unexp_q;
    assign unused_d = ^{tl_h_c_d.d_opcode, tl_h_c_d.d_param, tl_h_c_d.d_size,
                        tl_h_c_d.d_sink, tl_h_c_d.d_user, sel_addr[1:0]};
endmodule

// File: tb/tb_tlul_host_mux_adapter.sv
// Scoreboard bench: directed corner cases, then randomized masters and device.
module tb_tlul_host_mux_adapter;
    import tlul_pkg::*;
    localparam int NumCh   = 2;
    localparam int MaxReqs = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [NumCh-1:0]    req_i = '0;
    logic [NumCh-1:0]    we_i  = '0;
    logic [NumCh*32-1:0] addr_i = '0;
    logic [NumCh*32-1:0] wdata_i = '0;
    logic [NumCh*4-1:0]  be_i = '0;
    logic [NumCh-1:0]    gnt_o, valid_o, err_o;
    logic [NumCh*32-1:0] rdata_o;
    logic                unexp_o;
    tl_h2d_t             tl_h_c_a;
    tl_d2h_t             tl_h_c_d = '0;

    typedef struct { logic [2:0] op; logic [31:0] addr; logic [3:0] mask; logic [31:0] data; } a_exp_t;
    typedef struct { int ch; logic [31:0] data; logic err; } d_exp_t;

    a_exp_t exp_a[NumCh][$];
    d_exp_t exp_d[$];
    int     out_cnt[NumCh];
    int     dev_pend[NumCh];
    bit     granted[NumCh];
    int     rr_ptr = 0;
    int     locked_ch = -1;
    bit     mon_en = 1'b0;
    int     ncmp = 0;
    int     nmis = 0;

    always #5 clock = ~clock;

    tlul_host_mux_adapter #(.NumCh(NumCh), .MaxReqs(MaxReqs)) dut (
        .clock(clock), .reset(reset), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
        .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .valid_o(valid_o), .rdata_o(rdata_o),
        .err_o(err_o), .unexp_o(unexp_o), .tl_h_c_a(tl_h_c_a), .tl_h_c_d(tl_h_c_d)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: arbitration and A beat against the model, D routing against queued responses.
    task automatic mon_step();
        int     exp_ch;
        a_exp_t ea;
        d_exp_t ed;
        exp_ch = locked_ch;
        if (exp_ch < 0) begin
            for (int i = 0; i < NumCh; i++) begin
                int c;
                c = (rr_ptr + i) % NumCh;
                if (exp_ch < 0 && req_i[c] && out_cnt[c] < MaxReqs) exp_ch = c;
            end
        end
        chk("a_valid", 64'(tl_h_c_a.a_valid), 64'(exp_ch >= 0));
        if (exp_ch >= 0 && tl_h_c_a.a_valid) begin
            chk("a_source", 64'(tl_h_c_a.a_source), 64'(exp_ch));
            if (exp_a[exp_ch].size() == 0) begin
                chk("a_expect_queue_nonempty", 64'(0), 64'(1));
            end else begin
                ea = exp_a[exp_ch][0];
                chk("a_opcode",  64'(tl_h_c_a.a_opcode),  64'(ea.op));
                chk("a_address", 64'(tl_h_c_a.a_address), 64'(ea.addr));
                chk("a_mask",    64'(tl_h_c_a.a_mask),    64'(ea.mask));
                chk("a_data",    64'(tl_h_c_a.a_data),    64'(ea.data));
                chk("a_size",    64'(tl_h_c_a.a_size),    64'(2));
                if (tl_h_c_d.a_ready) begin
                    chk("gnt_o", 64'(gnt_o), 64'(1) << exp_ch);
                    void'(exp_a[exp_ch].pop_front());
                    out_cnt[exp_ch]++;
                    dev_pend[exp_ch]++;
                    granted[exp_ch] = 1'b1;
                    rr_ptr    = (exp_ch + 1) % NumCh;
                    locked_ch = -1;
                end else begin
                    chk("gnt_o_stalled", 64'(gnt_o), 64'(0));
                    locked_ch = exp_ch;
                end
            end
        end else begin
            chk("gnt_o_idle", 64'(gnt_o), 64'(0));
        end
        if (tl_h_c_d.d_valid) begin
            if (exp_d.size() == 0) begin
                chk("d_expect_queue_nonempty", 64'(0), 64'(1));
            end else begin
                ed = exp_d.pop_front();
                chk("valid_o", 64'(valid_o), 64'(1) << ed.ch);
                chk("rdata_o", 64'(rdata_o[ed.ch*32 +: 32]), 64'(ed.data));
                chk("err_o",   64'(err_o[ed.ch]), 64'(ed.err));
                out_cnt[ed.ch]--;
            end
        end else begin
            chk("valid_o_idle", 64'(valid_o), 64'(0));
        end
        chk("unexp_o_clear", 64'(unexp_o), 64'(0));
    endtask

    always @(negedge clock) if (mon_en) mon_step();

    // One cycle of random masters and random TL-UL device.
    task automatic drive_cycle(input bit issue);
        a_exp_t      ea;
        d_exp_t      ed;
        int          cand[$];
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr, wdata;
        for (int c = 0; c < NumCh; c++) begin
            if (granted[c]) begin req_i[c] = 1'b0; granted[c] = 1'b0; end
            if (!req_i[c] && issue && $urandom_range(0, 2) == 0) begin
                we    = 1'($urandom_range(0, 1));
                be    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
                addr  = $urandom;
                wdata = $urandom;
                req_i[c] = 1'b1;
                we_i[c]  = we;
                be_i[c*4 +: 4]     = be;
                addr_i[c*32 +: 32] = addr;
                wdata_i[c*32 +: 32] = wdata;
                ea.op   = we ? ((be == 4'hF) ? 3'h0 : 3'h1) : 3'h4;
                ea.addr = addr & 32'hFFFF_FFFC;
                ea.mask = we ? be : 4'hF;
                ea.data = we ? wdata : 32'h0;
                exp_a[c].push_back(ea);
            end
        end
        tl_h_c_d.a_ready = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < NumCh; c++) if (dev_pend[c] > 0) cand.push_back(c);
        if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            ed.ch   = cand[$urandom_range(0, cand.size() - 1)];
            ed.data = $urandom;
            ed.err  = ($urandom_range(0, 3) == 0);
            dev_pend[ed.ch]--;
            tl_h_c_d.d_valid  = 1'b1;
            tl_h_c_d.d_source = 8'(ed.ch);
            tl_h_c_d.d_data   = ed.data;
            tl_h_c_d.d_error  = ed.err;
            exp_d.push_back(ed);
        end else begin
            tl_h_c_d.d_valid = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic drive_d(input logic v, input logic [7:0] src, input logic [31:0] data, input logic e);
        tl_h_c_d.d_valid  = v;
        tl_h_c_d.d_source = src;
        tl_h_c_d.d_data   = data;
        tl_h_c_d.d_error  = e;
    endtask

    initial begin
        int cyc;
        // Reset values
        @(negedge clock);
        chk("rst_gnt_o",   64'(gnt_o), 64'(0));
        chk("rst_valid_o", 64'(valid_o), 64'(0));
        chk("rst_err_o",   64'(err_o), 64'(0));
        chk("rst_unexp_o", 64'(unexp_o), 64'(0));
        chk("rst_a_valid", 64'(tl_h_c_a.a_valid), 64'(0));
        chk("rst_d_ready", 64'(tl_h_c_a.d_ready), 64'(1));
        step(); reset = 1'b1;

        // Stalled partial write: A beat stable for 3 cycles, granted on the 4th
        step();
        req_i = 2'b01; we_i = 2'b01; be_i[3:0] = 4'b0011;
        addr_i[31:0] = 32'h1000_0006; wdata_i[31:0] = 32'hCAFE_0123;
        tl_h_c_d.a_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("stall_a_valid", 64'(tl_h_c_a.a_valid), 64'(1));
            chk("stall_opcode",  64'(tl_h_c_a.a_opcode), 64'(1));
            chk("stall_address", 64'(tl_h_c_a.a_address), 64'h1000_0004);
            chk("stall_mask",    64'(tl_h_c_a.a_mask), 64'h3);
            chk("stall_data",    64'(tl_h_c_a.a_data), 64'hCAFE_0123);
            chk("stall_gnt_o",   64'(gnt_o), 64'(0));
            step();
        end
        tl_h_c_d.a_ready = 1'b1;
        @(negedge clock);
        chk("stall_release_gnt", 64'(gnt_o), 64'b01);
        step(); req_i = '0; tl_h_c_d.a_ready = 1'b0;

        // Unexpected D beats: out-of-range source, then idle channel
        drive_d(1'b1, 8'd5, 32'h1111_1111, 1'b0);
        @(negedge clock); chk("unexp_src5_valid_o", 64'(valid_o), 64'(0));
        step(); drive_d(1'b1, 8'd1, 32'h2222_2222, 1'b0);
        @(negedge clock);
        chk("unexp_sticky_set", 64'(unexp_o), 64'(1));
        chk("unexp_idle_valid_o", 64'(valid_o), 64'(0));
        step(); drive_d(1'b1, 8'd0, 32'hDEAD_BEEF, 1'b1);
        @(negedge clock);
        chk("resp_valid_o", 64'(valid_o), 64'b01);
        chk("resp_rdata",   64'(rdata_o[31:0]), 64'hDEAD_BEEF);
        chk("resp_err",     64'(err_o[0]), 64'(1));
        step(); drive_d(1'b0, 8'd0, 32'h0, 1'b0);
        @(negedge clock);
        chk("resp_rdata_hold", 64'(rdata_o[31:0]), 64'hDEAD_BEEF);
        chk("resp_err_hold",   64'(err_o[0]), 64'(1));
        chk("unexp_still_set", 64'(unexp_o), 64'(1));

        // Fill ch0 to MaxReqs, lock on ch1, then reset mid-transaction
        step(); req_i = 2'b01; we_i = '0; tl_h_c_d.a_ready = 1'b1;
        @(negedge clock); chk("fill_gnt_1", 64'(gnt_o), 64'b01);
        step();
        @(negedge clock); chk("fill_gnt_2", 64'(gnt_o), 64'b01);
        step(); req_i = 2'b11; tl_h_c_d.a_ready = 1'b0;
        @(negedge clock);
        chk("full_ch_skipped_src", 64'(tl_h_c_a.a_source), 64'(1));
        chk("full_ch_gnt_o", 64'(gnt_o), 64'(0));
        step();
        @(negedge clock); chk("locked_a_valid", 64'(tl_h_c_a.a_valid), 64'(1));
        #1 reset = 1'b0;
        #1 chk("mid_rst_a_valid", 64'(tl_h_c_a.a_valid), 64'(0));
        chk("mid_rst_unexp", 64'(unexp_o), 64'(0));
        step(); reset = 1'b1; req_i = '0; drive_d(1'b1, 8'd0, 32'h3333_3333, 1'b0);
        @(negedge clock); chk("post_rst_inflight_valid_o", 64'(valid_o), 64'(0));
        step(); drive_d(1'b0, 8'd0, 32'h0, 1'b0); req_i = 2'b11; tl_h_c_d.a_ready = 1'b1;
        @(negedge clock);
        chk("post_rst_unexp", 64'(unexp_o), 64'(1));
        chk("post_rst_src",   64'(tl_h_c_a.a_source), 64'(0));
        chk("post_rst_gnt",   64'(gnt_o), 64'b01);

        // Randomized run from a clean reset
        step(); reset = 1'b0; req_i = '0; tl_h_c_d = '0;
        for (int c = 0; c < NumCh; c++) begin
            out_cnt[c] = 0; dev_pend[c] = 0; granted[c] = 1'b0; exp_a[c].delete();
        end
        exp_d.delete(); rr_ptr = 0; locked_ch = -1;
        step(); reset = 1'b1;
        mon_en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            drive_cycle(1'b1);
            @(posedge clock); #1;
        end
        // Drain with a bounded wait
        cyc = 0;
        while ((req_i != '0 || dev_pend[0] != 0 || dev_pend[1] != 0 || exp_d.size() != 0) && cyc < 1000) begin
            drive_cycle(1'b0);
            @(posedge clock); #1;
            cyc++;
        end
        chk("drain_completed", 64'(cyc < 1000), 64'(1));
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end
endmodule
